// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a framed program image from a byte stream into RAM, then releases the CPU
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        load_req,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_ren,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wmask,
  output logic [31:0] cpu_mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_ren,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_rdata,
  output logic        cpu_rst_n,
  output logic        loading,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, RUN, ERROR} state_t;
  state_t state, state_n;
  logic [15:0]         cnt;
  logic [ADDR_WIDTH:0] word_idx;
  logic [1:0]          byte_idx;
  logic [23:0]         asm_q;
  logic [7:0]          csum;
  logic                wr_v;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [31:0]         wr_data;
  logic                magic, cnt_over, last_word, run;
  assign magic     = rx_valid && rx_data == 8'hA5;
  assign cnt_over  = 32'({rx_data, cnt[7:0]}) > (32'd1 << ADDR_WIDTH);
  assign last_word = 32'(word_idx) + 32'd1 == 32'(cnt);
  assign run       = state == RUN;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // frame sequencing
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ERROR: if (magic) state_n = CNT_LO;
      CNT_LO:      if (rx_valid) state_n = CNT_HI;
      CNT_HI:      if (rx_valid) state_n = cnt_over ? ERROR : {rx_data, cnt[7:0]} == 16'd0 ? CSUM : DATA;
      DATA:        if (rx_valid && byte_idx == 2'd3 && last_word) state_n = CSUM;
      CSUM:        if (rx_valid) state_n = rx_data == csum ? RUN : ERROR;
      RUN:         if (load_req) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  // count/checksum capture, word assembly and the registered write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
      csum      <= '0;
      wr_v      <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      cpu_rst_n <= 1'b0;
    end else begin
      cpu_rst_n <= state_n == RUN;
      wr_v      <= 1'b0;
      if ((state == IDLE || state == ERROR) && magic) begin
        csum     <= '0;
        byte_idx <= '0;
        word_idx <= '0;
      end
      if (rx_valid && (state == CNT_LO || state == CNT_HI || state == DATA)) csum <= csum ^ rx_data;
      if (rx_valid && state == CNT_LO) cnt[7:0] <= rx_data;
      if (rx_valid && state == CNT_HI) begin
        cnt[15:8] <= rx_data;
        word_idx  <= '0;
        byte_idx  <= '0;
      end
      if (rx_valid && state == DATA) begin
        byte_idx <= byte_idx + 2'd1;
        asm_q    <= {rx_data, asm_q[23:8]};
        if (byte_idx == 2'd3) begin
          wr_v     <= 1'b1;
          wr_idx   <= word_idx[ADDR_WIDTH-1:0];
          wr_data  <= {rx_data, asm_q};
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end
  assign cpu_mem_rdata = ram_rdata;
  assign ram_addr      = run ? cpu_mem_addr : wr_v ? 32'({wr_idx, 2'b00}) : 32'd0;
  assign ram_ren       = run && cpu_mem_ren;
  assign ram_wdata     = run ? cpu_mem_wdata : wr_v ? wr_data : 32'd0;
  assign ram_wmask     = run ? cpu_mem_wmask : {4{wr_v}};
  assign loading       = state == CNT_LO || state == CNT_HI || state == DATA || state == CSUM;
  assign done          = run;
  assign error         = state == ERROR;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: randomized frame loads checked against a frame-level model and a RAM model
module tb_boot_loader_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, load_req = 1'b0, rxv = 1'b0, sel_small = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic [31:0] cpu_mem_addr = 32'h0, cpu_mem_wdata = 32'h0;
  logic cpu_mem_ren = 1'b0;
  logic [3:0] cpu_mem_wmask = 4'h0;
  logic [31:0] cpu_mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic ram_ren, cpu_rst_n, loading, done, error;
  logic [3:0] ram_wmask;
  logic [31:0] s_cpu_rdata, s_ram_addr, s_ram_wdata;
  logic s_ram_ren, s_cpu_rst_n, s_loading, s_done, s_error;
  logic [3:0] s_ram_wmask;
  logic [31:0] mem [4096];
  logic [31:0] s_mem [4];
  int wr_cnt = 0, s_wr_cnt = 0;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [31:0] img [16];
  boot_loader_ctrl #(.ADDR_WIDTH(12)) u_dut (
    .clk(clk), .rst(rst), .rx_valid(rxv && !sel_small), .rx_data(rxd), .load_req(load_req),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_ren(cpu_mem_ren), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wmask(cpu_mem_wmask), .cpu_mem_rdata(cpu_mem_rdata), .ram_addr(ram_addr),
    .ram_ren(ram_ren), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .done(done), .error(error));
  boot_loader_ctrl #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .rx_valid(rxv && sel_small), .rx_data(rxd), .load_req(1'b0),
    .cpu_mem_addr(32'h0), .cpu_mem_ren(1'b0), .cpu_mem_wdata(32'h0),
    .cpu_mem_wmask(4'h0), .cpu_mem_rdata(s_cpu_rdata), .ram_addr(s_ram_addr),
    .ram_ren(s_ram_ren), .ram_wdata(s_ram_wdata), .ram_wmask(s_ram_wmask), .ram_rdata(32'h0),
    .cpu_rst_n(s_cpu_rst_n), .loading(s_loading), .done(s_done), .error(s_error));
  wire [31:0] m = {{8{ram_wmask[3]}}, {8{ram_wmask[2]}}, {8{ram_wmask[1]}}, {8{ram_wmask[0]}}};
  // RAM models: byte-masked write, one-cycle read latency
  always @(posedge clk) begin
    if (ram_wmask != 4'h0) begin
      mem[ram_addr[13:2]] <= (mem[ram_addr[13:2]] & ~m) | (ram_wdata & m);
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_ren) ram_rdata <= mem[ram_addr[13:2]];
    if (s_ram_wmask != 4'h0) begin
      s_mem[s_ram_addr[3:2]] <= s_ram_wdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int gap);
    rxv = 1'b1;
    rxd = b;
    @(posedge clk); #1;
    rxv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask
  task automatic build_frame(input int n, input logic [7:0] flip);
    logic [7:0] cs, b;
    q.delete();
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        q.push_back(b);
        cs = cs ^ b;
      end
    q.push_back(cs ^ flip);
  endtask
  task automatic send_q(input int maxgap);
    logic [7:0] b;
    while (q.size() > 0) begin
      b = q.pop_front();
      send_byte(b, $urandom_range(maxgap, 0));
    end
  endtask
  task automatic pulse_load;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask
  task automatic do_rst;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic set_nominal;
    img[0] = 32'h02A00513;
    img[1] = 32'h00100073;
  endtask
  task automatic test_reset;
    cpu_mem_addr = 32'h10; cpu_mem_ren = 1'b1; cpu_mem_wmask = 4'hF; cpu_mem_wdata = 32'h12345678;
    repeat (3) begin @(posedge clk); #1; end
    total++; if ({cpu_rst_n, loading, done, error} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {cpu_rst_n, loading, done, error}); end
    total++; if (ram_ren !== 1'b0 || ram_wmask !== 4'h0) begin bad++; $display("FAIL reset_ren_mask got=%b/%h exp=0/0", ram_ren, ram_wmask); end
    total++; if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", ram_addr, ram_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (ram_wmask !== 4'h0 || ram_ren !== 1'b0 || cpu_rst_n !== 1'b0) begin bad++; $display("FAIL idle_cpu_ignored got=%h/%b/%b exp=0/0/0", ram_wmask, ram_ren, cpu_rst_n); end
    cpu_mem_addr = 32'h0; cpu_mem_ren = 1'b0; cpu_mem_wmask = 4'h0; cpu_mem_wdata = 32'h0;
  endtask
  task automatic test_nominal;
    int base;
    logic [7:0] b;
    set_nominal();
    build_frame(2, 8'h00);
    base = wr_cnt;
    b = q.pop_front();
    send_byte(b, 0);
    total++; if (loading !== 1'b1) begin bad++; $display("FAIL nom_loading got=%b exp=1", loading); end
    send_q(0);
    total++; if (done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL nom_run got=%b%b%b exp=110", done, cpu_rst_n, error); end
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL nom_writes got=%0d exp=2", wr_cnt - base); end
    total++; if (mem[0] !== 32'h02A00513) begin bad++; $display("FAIL nom_mem0 got=%h exp=02a00513", mem[0]); end
    total++; if (mem[1] !== 32'h00100073) begin bad++; $display("FAIL nom_mem1 got=%h exp=00100073", mem[1]); end
  endtask
  task automatic test_passthru_reload;
    int base;
    cpu_mem_addr = 32'h4; cpu_mem_ren = 1'b1;
    #1;
    total++; if (ram_ren !== 1'b1 || ram_addr !== 32'h4) begin bad++; $display("FAIL pt_ren got=%b/%h exp=1/4", ram_ren, ram_addr); end
    @(posedge clk); #1;
    cpu_mem_ren = 1'b0;
    total++; if (cpu_mem_rdata !== 32'h00100073) begin bad++; $display("FAIL pt_rdata got=%h exp=00100073", cpu_mem_rdata); end
    cpu_mem_addr = 32'h8; cpu_mem_wdata = 32'hDEADBEEF; cpu_mem_wmask = 4'b0011;
    @(posedge clk); #1;
    total++; if (mem[2][15:0] !== 16'hBEEF) begin bad++; $display("FAIL pt_store got=%h exp=beef", mem[2][15:0]); end
    cpu_mem_addr = 32'hC; cpu_mem_wmask = 4'hF;
    pulse_load();
    total++; if (cpu_rst_n !== 1'b0 || ram_wmask !== 4'h0 || done !== 1'b0) begin bad++; $display("FAIL reload_hold got=%b/%h/%b exp=0/0/0", cpu_rst_n, ram_wmask, done); end
    cpu_mem_addr = 32'h0; cpu_mem_wmask = 4'h0; cpu_mem_wdata = 32'h0;
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    build_frame(3, 8'h00);
    base = wr_cnt;
    send_q(0);
    total++; if (done !== 1'b1 || wr_cnt - base !== 3) begin bad++; $display("FAIL reload_run got=%b/%0d exp=1/3", done, wr_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem[i] !== img[i]) begin bad++; $display("FAIL reload_mem%0d got=%h exp=%h", i, mem[i], img[i]); end
    end
  endtask
  task automatic test_noise_gaps;
    int base;
    do_rst();
    set_nominal();
    base = wr_cnt;
    send_byte(8'h00, $urandom_range(5, 0));
    send_byte(8'hFF, $urandom_range(5, 0));
    build_frame(2, 8'h00);
    send_q(5);
    total++; if (done !== 1'b1 || wr_cnt - base !== 2) begin bad++; $display("FAIL noise_run got=%b/%0d exp=1/2", done, wr_cnt - base); end
    total++; if (mem[0] !== 32'h02A00513 || mem[1] !== 32'h00100073) begin bad++; $display("FAIL noise_mem got=%h,%h exp=02a00513,00100073", mem[0], mem[1]); end
  endtask
  task automatic test_bad_csum;
    int base;
    pulse_load();
    set_nominal();
    build_frame(2, 8'h15);
    base = wr_cnt;
    send_q(0);
    total++; if (error !== 1'b1 || cpu_rst_n !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL bad_csum got=%b%b%b exp=100", error, cpu_rst_n, done); end
    repeat (5) begin @(posedge clk); #1; end
    total++; if (wr_cnt - base !== 2 || ram_ren !== 1'b0) begin bad++; $display("FAIL bad_csum_quiet got=%0d/%b exp=2/0", wr_cnt - base, ram_ren); end
    build_frame(2, 8'h00);
    send_q(1);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL err_recover got=%b%b exp=10", done, error); end
  endtask
  task automatic test_zero_oversize;
    int base;
    pulse_load();
    base = wr_cnt;
    build_frame(0, 8'h00);
    send_q(0);
    total++; if (done !== 1'b1 || wr_cnt - base !== 0) begin bad++; $display("FAIL zero_cnt got=%b/%0d exp=1/0", done, wr_cnt - base); end
    pulse_load();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    total++; if (error !== 1'b1 || loading !== 1'b0 || wr_cnt - base !== 0) begin bad++; $display("FAIL oversize got=%b/%b/%0d exp=1/0/0", error, loading, wr_cnt - base); end
    sel_small = 1'b1;
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    total++; if (s_error !== 1'b1) begin bad++; $display("FAIL small_oversize got=%b exp=1", s_error); end
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    base = s_wr_cnt;
    build_frame(4, 8'h00);
    send_q(1);
    total++; if (s_done !== 1'b1 || s_cpu_rst_n !== 1'b1 || s_wr_cnt - base !== 4) begin bad++; $display("FAIL small_full got=%b/%b/%0d exp=1/1/4", s_done, s_cpu_rst_n, s_wr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      total++; if (s_mem[i] !== img[i]) begin bad++; $display("FAIL small_mem%0d got=%h exp=%h", i, s_mem[i], img[i]); end
    end
    sel_small = 1'b0;
  endtask
  task automatic test_random;
    int base, n;
    logic [7:0] flip, b;
    for (int it = 0; it < 8; it++) begin
      if (done) pulse_load();
      for (int k = $urandom_range(2, 0); k > 0; k--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b, $urandom_range(2, 0));
      end
      n = $urandom_range(6, 0);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      build_frame(n, flip);
      base = wr_cnt;
      send_q(3);
      total++; if ({done, error, cpu_rst_n} !== (flip == 0 ? 3'b101 : 3'b010)) begin bad++; $display("FAIL rand%0d_state got=%b exp=%b", it, {done, error, cpu_rst_n}, flip == 0 ? 3'b101 : 3'b010); end
      total++; if (wr_cnt - base !== n) begin bad++; $display("FAIL rand%0d_writes got=%0d exp=%0d", it, wr_cnt - base, n); end
      for (int i = 0; i < n; i++) begin
        total++; if (mem[i] !== img[i]) begin bad++; $display("FAIL rand%0d_mem%0d got=%h exp=%h", it, i, mem[i], img[i]); end
      end
    end
  endtask
  task automatic test_reset_midframe;
    int base;
    do_rst();
    base = wr_cnt;
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if ({cpu_rst_n, loading, done, error} !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags got=%b exp=0000", {cpu_rst_n, loading, done, error}); end
    total++; if (ram_wmask !== 4'h0 || ram_ren !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin bad++; $display("FAIL mid_rst_ram got=%h/%b/%h/%h exp=0/0/0/0", ram_wmask, ram_ren, ram_addr, ram_wdata); end
    rst = 1'b0;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    repeat (3) begin @(posedge clk); #1; end
    total++; if (wr_cnt - base !== 0 || loading !== 1'b0) begin bad++; $display("FAIL mid_rst_nowrite got=%0d/%b exp=0/0", wr_cnt - base, loading); end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_passthru_reload();
    test_noise_gaps();
    test_bad_csum();
    test_zero_oversize();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
